lcd_frame_seq: RTL



---
 rtl/lcd_frame_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_seq.sv
// Power-up/init sequencer and 32-character frame redraw for a 16x2 HD44780 LCD.
// Optional LCD_FRAME_SKIP_SAME_EN: a request for the message already on screen completes without a redraw.
module lcd_frame_seq #(
  parameter int POWERUP_CYC = 1000000,
  parameter int SETUP_CYC   = 4,
  parameter int EN_HIGH_CYC = 25,
  parameter int SETTLE_CYC  = 2500,
  parameter int CLEAR_CYC   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] msg_sel,
  output logic       busy,
  output logic       done,
  output logic       LCD_ON,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS,
  inout  wire  [7:0] LCD_DATA
);

  // state  | meaning
  // PWRUP  | wait POWERUP_CYC after reset before the first init command
  // IDLE   | init finished, waiting for req
  // SETUP  | RS/DATA driven, EN low
  // EN_HI  | EN strobe high
  // SETTLE | EN low, waiting for the LCD to execute the byte
  // DONE   | one-cycle done pulse; behaves like IDLE for the next req
  // Init bytes (in_init=1) and frame bytes share SETUP/EN_HI/SETTLE.
  typedef enum logic [2:0] {
    S_PWRUP, S_IDLE, S_SETUP, S_EN_HI, S_SETTLE, S_DONE
  } state_t;

  localparam logic [31:0] T_PWR   = 32'(POWERUP_CYC - 1);
  localparam logic [31:0] T_SETUP = 32'(SETUP_CYC - 1);
  localparam logic [31:0] T_EN    = 32'(EN_HIGH_CYC - 1);
  localparam logic [31:0] T_SET   = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] T_CLR   = 32'(CLEAR_CYC - 1);

  localparam logic [127:0] L1_Q1  = "Question 1      ";
  localparam logic [127:0] L1_Q2  = "Question 2      ";
  localparam logic [127:0] L1_OK  = "Correct!        ";
  localparam logic [127:0] L1_BAD = "Wrong - retry   ";
  localparam logic [127:0] L2_SW  = "Enter on SW[9:0]";
  localparam logic [127:0] L2_SP  = "                ";

  state_t      state;
  logic [31:0] tmr;
  logic [5:0]  step;
  logic [1:0]  init_idx;
  logic        in_init;
  logic [1:0]  msg_q;
  logic [7:0]  data_q;
  logic [31:0] settle_last;
`ifdef LCD_FRAME_SKIP_SAME_EN
  logic [1:0]  last_msg;
  logic        last_vld;
`endif

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Returns {rs, data} for frame step s of message m.
  function automatic logic [8:0] frame_byte(input logic [1:0] m, input logic [5:0] s);
    logic [127:0] l1;
    logic [127:0] l2;
    logic [3:0]   col;
    logic [6:0]   lo;
    case (m)
      2'd0:    begin l1 = L1_Q1;  l2 = L2_SW; end
      2'd1:    begin l1 = L1_Q2;  l2 = L2_SW; end
      2'd2:    begin l1 = L1_OK;  l2 = L2_SP; end
      default: begin l1 = L1_BAD; l2 = L2_SP; end
    endcase
    if (s == 6'd0) return 9'h080;
    if (s == 6'd17) return 9'h0C0;
    col = (s <= 6'd16) ? 4'(s - 6'd1) : 4'(s - 6'd18);
    lo  = {4'd15 - col, 3'b000};
    return (s <= 6'd16) ? {1'b1, l1[lo +: 8]} : {1'b1, l2[lo +: 8]};
  endfunction

  assign LCD_ON   = 1'b1;
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = data_q;
  assign settle_last = (!LCD_RS && data_q == 8'h01) ? T_CLR : T_SET;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_PWRUP;
      tmr      <= '0;
      step     <= '0;
      init_idx <= '0;
      in_init  <= 1'b1;
      msg_q    <= '0;
      data_q   <= '0;
      LCD_RS   <= 1'b0;
      LCD_EN   <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
`ifdef LCD_FRAME_SKIP_SAME_EN
      last_msg <= '0;
      last_vld <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_PWRUP: begin
          if (tmr == T_PWR) begin
            tmr      <= '0;
            init_idx <= '0;
            in_init  <= 1'b1;
            LCD_RS   <= 1'b0;
            data_q   <= init_cmd(2'd0);
            state    <= S_SETUP;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        S_IDLE, S_DONE: begin
          if (req) begin
            msg_q <= msg_sel;
            step  <= '0;
            tmr   <= '0;
            busy  <= 1'b1;
`ifdef LCD_FRAME_SKIP_SAME_EN
            if (last_vld && msg_sel == last_msg) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else
`endif
            begin
              {LCD_RS, data_q} <= frame_byte(msg_sel, 6'd0);
              state <= S_SETUP;
            end
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_SETUP: begin
          if (tmr == T_SETUP) begin
            tmr    <= '0;
            LCD_EN <= 1'b1;
            state  <= S_EN_HI;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        S_EN_HI: begin
          if (tmr == T_EN) begin
            tmr    <= '0;
            LCD_EN <= 1'b0;
            state  <= S_SETTLE;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        S_SETTLE: begin
          if (tmr == settle_last) begin
            tmr <= '0;
            if (in_init) begin
              if (init_idx == 2'd3) begin
                in_init <= 1'b0;
                busy    <= 1'b0;
                state   <= S_IDLE;
              end else begin
                init_idx <= init_idx + 2'd1;
                LCD_RS   <= 1'b0;
                data_q   <= init_cmd(init_idx + 2'd1);
                state    <= S_SETUP;
              end
            end else if (step == 6'd33) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
`ifdef LCD_FRAME_SKIP_SAME_EN
              last_msg <= msg_q;
              last_vld <= 1'b1;
`endif
            end else begin
              step <= step + 6'd1;
              {LCD_RS, data_q} <= frame_byte(msg_q, step + 6'd1);
              state <= S_SETUP;
            end
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule
